// File: rtl/ext_stim_check_sequencer_if.sv
// Stimulus/response bundle between the sequencer and the harness.
// The master side drives foo and the status outputs, and samples bar and start.
interface ext_stim_check_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] foo;
  logic [DATA_W-1:0] bar;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        err_count;
  logic [15:0]       vec_idx;

  modport master (
    input  start,
    input  bar,
    output foo,
    output busy,
    output done,
    output pass,
    output err_count,
    output vec_idx
  );

  modport slave (
    output start,
    output bar,
    input  foo,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  vec_idx
  );
endinterface

// File: rtl/ext_stim_check_sequencer.sv
// Drives an incrementing vector run on foo and checks bar against
// foo delayed by LATENCY cycles, reporting a saturating error count.
module ext_stim_check_sequencer #(
  parameter int                DATA_W      = 16,
  parameter int                SEED_W      = 11,
  parameter logic [SEED_W-1:0] SEED        = 11'h4D2,
  parameter logic [DATA_W-1:0] STEP        = 1,
  parameter int                NUM_VECTORS = 4,
  parameter int                LATENCY     = 2
) (
  input  logic clock,
  input  logic reset,
  ext_stim_check_sequencer_if.master io
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_e;

  localparam logic [DATA_W-1:0] SEED_X = DATA_W'(SEED);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [4:0] DRAIN_LAST = 5'(LATENCY - 1);

  state_e state_q, state_d;
  logic [DATA_W-1:0] foo_q, foo_d;
  logic [15:0] vec_idx_q, vec_idx_d;
  logic [7:0] err_count_q, err_count_d;
  logic [4:0] drain_cnt_q, drain_cnt_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic mismatch;

  logic [LATENCY-1:0] exp_vld_q, exp_vld_d;
  logic [LATENCY-1:0][DATA_W-1:0] exp_val_q, exp_val_d;

  always_comb begin
    state_d     = state_q;
    foo_d       = foo_q;
    vec_idx_d   = vec_idx_q;
    err_count_d = err_count_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;

    // Entry slot holds what foo carries this cycle.
    exp_vld_d    = '0;
    exp_val_d    = '0;
    exp_vld_d[0] = (state_q == DRIVE);
    exp_val_d[0] = foo_q;
    for (int i = 1; i < LATENCY; i++) begin
      exp_vld_d[i] = exp_vld_q[i-1];
      exp_val_d[i] = exp_val_q[i-1];
    end

    mismatch = exp_vld_q[LATENCY-1] &&
               (io.bar != exp_val_q[LATENCY-1]);
    if (mismatch && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (io.start) begin
          state_d     = DRIVE;
          foo_d       = SEED_X;
          vec_idx_d   = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
        end
      end
      DRIVE: begin
        if (vec_idx_q == LAST_IDX) begin
          state_d     = DRAIN;
          foo_d       = '0;
          drain_cnt_d = '0;
        end else begin
          foo_d     = foo_q + STEP;
          vec_idx_d = vec_idx_q + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          // Last in-flight check lands this cycle; fold it into pass.
          state_d = DONE;
          pass_d  = (err_count_d == 8'd0);
        end else begin
          drain_cnt_d = drain_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      foo_q       <= '0;
      vec_idx_q   <= '0;
      err_count_q <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exp_vld_q   <= '0;
      exp_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      foo_q       <= foo_d;
      vec_idx_q   <= vec_idx_d;
      err_count_q <= err_count_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exp_vld_q   <= exp_vld_d;
      exp_val_q   <= exp_val_d;
    end
  end

  assign io.foo       = foo_q;
  assign io.vec_idx   = vec_idx_q;
  assign io.err_count = err_count_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.pass      = pass_q;

endmodule

// File: tb/tb_ext_stim_check_sequencer.sv
// Scoreboard bench: runs queue expected foo streams and results,
// monitors pop and compare as the sequencers present them.
module tb_ext_stim_check_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] err;
    logic       pass;
  } res_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   mode;

  logic [15:0] qfa[$];
  logic [15:0] qfb[$];
  res_t        qra[$];
  res_t        qrb[$];

  logic [15:0] da1, da2, db1, db2;
  logic        pda, pdb;

  ext_stim_check_sequencer_if #(.DATA_W(16)) ia ();
  ext_stim_check_sequencer_if #(.DATA_W(16)) ib ();

  ext_stim_check_sequencer u_a (
    .clock(clock),
    .reset(reset),
    .io   (ia)
  );

  ext_stim_check_sequencer #(
    .SEED_W     (16),
    .SEED       (16'hFFFE),
    .NUM_VECTORS(300)
  ) u_b (
    .clock(clock),
    .reset(reset),
    .io   (ib)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Black-box stand-in: 2-cycle delay with selectable fault modes.
  always @(posedge clock) begin
    da1 <= ia.foo;
    da2 <= da1;
    db1 <= ib.foo;
    db2 <= db1;
  end

  always_comb begin
    ia.bar = da2;
    ib.bar = db2;
    case (mode)
      1: ia.bar = 16'h0000;
      2: ia.bar = (da2 == 16'h04D4) ? 16'h04D0 : da2;
      3: ib.bar = ~db2;
      default: ;
    endcase
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic plan(bit b, logic [15:0] seed, int n, int nseen,
                      bit fin, logic [7:0] err, bit pass);
    res_t r;
    logic [15:0] v;
    for (int i = 0; i < nseen; i++) begin
      v = (i < n) ? 16'(seed + 16'(i)) : 16'h0000;
      if (b) qfb.push_back(v);
      else qfa.push_back(v);
    end
    if (fin) begin
      r.cyc  = cyc + n + 3;
      r.err  = err;
      r.pass = pass;
      if (b) qrb.push_back(r);
      else qra.push_back(r);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_foo"}, 32'(ia.foo), 0);
    chk({tag, "_busy"}, 32'(ia.busy), 0);
    chk({tag, "_done"}, 32'(ia.done), 0);
    chk({tag, "_pass"}, 32'(ia.pass), 0);
    chk({tag, "_err"}, 32'(ia.err_count), 0);
    chk({tag, "_idx"}, 32'(ia.vec_idx), 0);
  endtask

  // Monitor for instance A.
  always @(negedge clock) begin
    res_t r;
    if (ia.busy === 1'b1) begin
      if (qfa.size() == 0) begin
        chk("a_foo_unexpected", 32'(ia.foo), 32'hDEAD_BEEF);
      end else begin
        chk("a_foo", 32'(ia.foo), 32'(qfa.pop_front()));
      end
    end
    if (ia.done === 1'b1 && pda !== 1'b1) begin
      if (qra.size() == 0) begin
        chk("a_done_unexpected", 32'(ia.done), 0);
      end else begin
        r = qra.pop_front();
        chk("a_done_cyc", cyc, r.cyc);
        chk("a_err", 32'(ia.err_count), 32'(r.err));
        chk("a_pass", 32'(ia.pass), 32'(r.pass));
      end
    end
    pda <= ia.done;
  end

  // Monitor for instance B.
  always @(negedge clock) begin
    res_t r;
    if (ib.busy === 1'b1) begin
      if (qfb.size() == 0) begin
        chk("b_foo_unexpected", 32'(ib.foo), 32'hDEAD_BEEF);
      end else begin
        chk("b_foo", 32'(ib.foo), 32'(qfb.pop_front()));
      end
    end
    if (ib.done === 1'b1 && pdb !== 1'b1) begin
      if (qrb.size() == 0) begin
        chk("b_done_unexpected", 32'(ib.done), 0);
      end else begin
        r = qrb.pop_front();
        chk("b_done_cyc", cyc, r.cyc);
        chk("b_err", 32'(ib.err_count), 32'(r.err));
        chk("b_pass", 32'(ib.pass), 32'(r.pass));
      end
    end
    pdb <= ib.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    mode     = 0;
    reset    = 1'b0;
    ia.start = 1'b0;
    ib.start = 1'b0;
    tick(3);
    chk_reset("rst");
    chk("rst_b_busy", 32'(ib.busy), 0);
    chk("rst_b_done", 32'(ib.done), 0);
    reset = 1'b1;
    tick(1);

    // Loopback run.
    mode = 0;
    plan(0, 16'h04D2, 4, 6, 1, 8'd0, 1);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(9);
    chk("hold_done", 32'(ia.done), 1);
    chk("hold_pass", 32'(ia.pass), 1);
    tick(1);

    // Stuck-at-zero response.
    mode = 1;
    plan(0, 16'h04D2, 4, 6, 1, 8'd4, 0);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(10);

    // Only the third response corrupted.
    mode = 2;
    plan(0, 16'h04D2, 4, 6, 1, 8'd1, 0);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(10);

    // Reset in the second DRIVE cycle aborts the run.
    mode = 1;
    plan(0, 16'h04D2, 4, 2, 0, 8'd0, 0);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk_reset("abort");
    reset = 1'b1;
    mode  = 0;
    tick(1);
    plan(0, 16'h04D2, 4, 6, 1, 8'd0, 1);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(10);

    // start while busy ignored; start in DONE launches a new run.
    plan(0, 16'h04D2, 4, 6, 1, 8'd0, 1);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(1);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    tick(5);
    plan(0, 16'h04D2, 4, 6, 1, 8'd0, 1);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    chk("restart_done", 32'(ia.done), 0);
    chk("restart_pass", 32'(ia.pass), 0);
    tick(9);

    // Instance B: wrap across 0xFFFF, then saturating error count.
    mode = 0;
    plan(1, 16'hFFFE, 300, 302, 1, 8'd0, 1);
    ib.start = 1'b1;
    tick(1);
    ib.start = 1'b0;
    tick(308);
    mode = 3;
    plan(1, 16'hFFFE, 300, 302, 1, 8'd255, 0);
    ib.start = 1'b1;
    tick(1);
    ib.start = 1'b0;
    tick(308);

    chk("qfa_left", qfa.size(), 0);
    chk("qra_left", qra.size(), 0);
    chk("qfb_left", qfb.size(), 0);
    chk("qrb_left", qrb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
